sinc_post_proc: RTL and testbench

SINC_POST_PROC -- requirements
Module: sinc_post_proc

---
 rtl/sinc_post_proc.sv | 137 +++++++++++++
 tb/tb_sinc_post_proc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sinc_post_proc.sv
// SINC3 post-processing: offset removal, Q2.14 gain with saturation, over-range trip detect, FWFT output FIFO.
// Latency: sample strobed on edge k is written to the FIFO on edge k+2 and visible on DOUT the cycle after.
// Backpressure: DOUT_RDY only pops the FIFO; the pipeline never stalls, a write into a full FIFO without a pop is dropped and sets OVF.
module sinc_post_proc #(
  parameter int FIFO_DEPTH = 4,
  parameter int TRIP_CNT   = 3
) (
  input  logic                          MCLK,
  input  logic                          RST,
  input  logic [15:0]                   DIN,
  input  logic                          DIN_VLD,
  input  logic [15:0]                   OFFSET,
  input  logic [15:0]                   GAIN,
  input  logic [15:0]                   THRESH,
  input  logic                          FAULT_CLR,
  output logic [15:0]                   DOUT,
  output logic                          DOUT_VLD,
  input  logic                          DOUT_RDY,
  output logic                          FAULT,
  output logic                          OVF,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    TRIP_MAX = 4'(TRIP_CNT);

  // pipeline registers
  logic        s1_vld;
  logic [15:0] d1;
  logic        s2_vld;
  logic [15:0] d2;

  // FIFO storage and pointers
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic [3:0]  trip;

  logic [15:0] d1_nxt;
  logic [31:0] scaled;
  logic [15:0] d2_nxt;
  logic        pop;
  logic        full;
  logic        push;
  logic        drop;
  logic        hit;
  logic [3:0]  trip_inc;
  logic        reach;

  // clamp negative offset results to zero; scale the full 32-bit product back by 2^14 and saturate
  always_comb begin
    d1_nxt   = (DIN >= OFFSET) ? (DIN - OFFSET) : 16'h0000;
    scaled   = (32'(d1) * 32'(GAIN)) >> 14;
    d2_nxt   = (scaled > 32'h0000_FFFF) ? 16'hFFFF : scaled[15:0];
    pop      = (cnt != '0) && DOUT_RDY;
    full     = (cnt == FULL_CNT);
    push     = s2_vld && (!full || pop);
    drop     = s2_vld && full && !pop;
    hit      = (d2 > THRESH);
    trip_inc = (trip == TRIP_MAX) ? TRIP_MAX : trip + 4'd1;
    reach    = s2_vld && hit && (trip_inc == TRIP_MAX);
  end

  // stage 1: capture and offset-correct each strobed sample
  always_ff @(posedge MCLK) begin
    if (RST) begin
      s1_vld <= 1'b0;
      d1     <= 16'h0000;
    end else begin
      s1_vld <= DIN_VLD;
      if (DIN_VLD) d1 <= d1_nxt;
    end
  end

  // stage 2: apply gain with the GAIN value present at this stage
  always_ff @(posedge MCLK) begin
    if (RST) begin
      s2_vld <= 1'b0;
      d2     <= 16'h0000;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) d2 <= d2_nxt;
    end
  end

  // FIFO storage write; contents behind the read pointer are don't-care
  always_ff @(posedge MCLK) begin
    if (push) mem[wptr] <= d2;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge MCLK) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      OVF  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) OVF <= 1'b1;
    end
  end

  // trip counter and sticky fault; reaching the limit beats a simultaneous clear
  always_ff @(posedge MCLK) begin
    if (RST) begin
      trip  <= 4'd0;
      FAULT <= 1'b0;
    end else if (reach) begin
      trip  <= TRIP_MAX;
      FAULT <= 1'b1;
    end else if (FAULT_CLR) begin
      trip  <= 4'd0;
      FAULT <= 1'b0;
    end else if (s2_vld) begin
      trip  <= hit ? trip_inc : 4'd0;
    end
  end

  // head of FIFO is driven from registered state only, never from DOUT_RDY
  always_comb begin
    DOUT_VLD = (cnt != '0);
    DOUT     = DOUT_VLD ? mem[rptr] : 16'h0000;
    FIFO_CNT = cnt;
  end

endmodule

// File: tb/tb_sinc_post_proc.sv
// Testbench for sinc_post_proc: directed scenarios followed by randomized traffic.
// Every edge is mirrored by a queue-based reference model and all outputs compared.
// Outputs are sampled 1 time unit after the rising edge.
module tb_sinc_post_proc;

  localparam int DEPTH = 4;
  localparam int TRIP  = 3;

  logic        mclk;
  logic        rst;
  logic [15:0] din;
  logic        din_vld;
  logic [15:0] offset;
  logic [15:0] gain;
  logic [15:0] thresh;
  logic        fault_clr;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        fault;
  logic        ovf;
  logic [$clog2(DEPTH):0] fifo_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_q[$];
  int m_s1v, m_s1d, m_s2v, m_s2d;
  int m_trip, m_fault, m_ovf;

  sinc_post_proc #(.FIFO_DEPTH(DEPTH), .TRIP_CNT(TRIP)) dut (
    .MCLK(mclk), .RST(rst), .DIN(din), .DIN_VLD(din_vld), .OFFSET(offset),
    .GAIN(gain), .THRESH(thresh), .FAULT_CLR(fault_clr), .DOUT(dout),
    .DOUT_VLD(dout_vld), .DOUT_RDY(dout_rdy), .FAULT(fault), .OVF(ovf),
    .FIFO_CNT(fifo_cnt)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock edge of the behavioural model, using the inputs held across the edge
  task automatic model_edge();
    bit pop, full, hit;
    int tn;
    longint p;
    if (rst) begin
      m_q.delete();
      m_s1v = 0; m_s1d = 0; m_s2v = 0; m_s2d = 0;
      m_trip = 0; m_fault = 0; m_ovf = 0;
    end else begin
      pop  = (m_q.size() > 0) && dout_rdy;
      full = (m_q.size() == DEPTH);
      hit  = (m_s2d > int'(thresh));
      tn   = hit ? ((m_trip + 1 > TRIP) ? TRIP : m_trip + 1) : 0;
      if (m_s2v != 0 && hit && tn == TRIP) begin
        m_fault = 1; m_trip = TRIP;
      end else if (fault_clr) begin
        m_fault = 0; m_trip = 0;
      end else if (m_s2v != 0) begin
        m_trip = tn;
      end
      if (pop) void'(m_q.pop_front());
      if (m_s2v != 0) begin
        if (full && !pop) m_ovf = 1;
        else m_q.push_back(m_s2d);
      end
      p     = (longint'(m_s1d) * longint'(gain)) / 16384;
      m_s2d = (p > 65535) ? 65535 : int'(p);
      m_s2v = m_s1v;
      m_s1v = din_vld ? 1 : 0;
      m_s1d = (din >= offset) ? int'(din) - int'(offset) : 0;
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    model_edge();
    #1;
    chk("dout_vld", 32'(dout_vld), (m_q.size() > 0) ? 32'd1 : 32'd0);
    chk("dout",     32'(dout),     (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
    chk("fault",    32'(fault),    32'(m_fault));
    chk("ovf",      32'(ovf),      32'(m_ovf));
  endtask

  task automatic send(input logic [15:0] v);
    din = v; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vld = 1'b0; offset = '0; gain = 16'h4000;
    thresh = 16'hFFFF; fault_clr = 1'b0; dout_rdy = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    rst = 1'b0;

    // offset/unity gain, sample strobed on the first edge after reset
    offset = 16'h1000; gain = 16'h4000;
    send(16'h3000);
    tick();
    chk("lat_k1_empty", 32'(dout_vld), 32'd0);
    tick();
    chk("lat_vld", 32'(dout_vld), 32'd1);
    chk("lat_dout", 32'(dout), 32'h2000);

    // saturation and negative clamp
    dout_rdy = 1'b1;
    tick();
    offset = 16'h0000; gain = 16'h8000;
    send(16'hC000);
    tick(); tick();
    chk("sat_dout", 32'(dout), 32'hFFFF);
    offset = 16'h1000;
    send(16'h0800);
    tick(); tick();
    chk("clamp_vld", 32'(dout_vld), 32'd1);
    chk("clamp_dout", 32'(dout), 32'h0000);
    tick();

    // overflow: five samples into a stalled four-entry FIFO
    dout_rdy = 1'b0; offset = 16'h0000; gain = 16'h4000;
    for (int i = 1; i <= 5; i++) send(16'(i));
    tick(); tick();
    chk("ovf_cnt", 32'(fifo_cnt), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    dout_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", 32'(dout), 32'(i));
      tick();
    end
    chk("ovf_drained", 32'(dout_vld), 32'd0);

    // trip counter and sticky fault with clear
    thresh = 16'h1000;
    send(16'h2000); send(16'h2000); send(16'h0800); send(16'h2000); send(16'h2000);
    tick(); tick(); tick();
    chk("trip_no_fault", 32'(fault), 32'd0);
    send(16'h2000);
    tick(); tick();
    chk("trip_fault", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("trip_clear", 32'(fault), 32'd0);
    thresh = 16'hFFFF;

    // full FIFO with simultaneous pop and write
    do_reset();
    dout_rdy = 1'b0;
    send(16'd10); send(16'd20); send(16'd30); send(16'd40);
    tick(); tick();
    send(16'd50);
    tick();
    dout_rdy = 1'b1;
    tick();
    chk("fullpop_cnt", 32'(fifo_cnt), 32'd4);
    chk("fullpop_ovf", 32'(ovf), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_order", 32'(dout), 32'(i * 10));
      tick();
    end

    // reset with samples in the FIFO and in the pipeline
    dout_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) send(16'(i));
    chk("inflight_cnt", 32'(fifo_cnt), 32'd3);
    do_reset();
    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", 32'(dout_vld), 32'd0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      din       = 16'($urandom);
      din_vld   = ($urandom_range(0, 3) != 0);
      offset    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h2000)) : 16'($urandom);
      gain      = 16'($urandom);
      thresh    = 16'($urandom_range(0, 16'hC000));
      fault_clr = ($urandom_range(0, 15) == 0);
      dout_rdy  = ($urandom_range(0, 9) < 5);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
